array_pair_serializer: RTL and testbench

//  Downstream consumer of the int_2 array stream produced on a b_out/sync/notify port.

---
 rtl/array_pair_serializer_pkg.sv | 11 +
 rtl/scam_model_types_pkg.sv | 5 +
 rtl/array_pair_serializer_pair_fifo.sv | 55 +++++
 rtl/array_pair_serializer.sv | 93 +++++++++
 tb/tb_array_pair_serializer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/array_pair_serializer_pkg.sv
// rtl/array_pair_serializer_pkg.sv - output FSM states and reset constants for the pair serializer
package array_pair_serializer_types;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_t;

  localparam logic [31:0] ELEMS_SENT_RESET = 32'd0;
  localparam logic [31:0] B_OUT_IDLE       = 32'd0;
endpackage

// File: rtl/scam_model_types_pkg.sv
// rtl/scam_model_types_pkg.sv - shared model types: two-element signed integer array
package scam_model_types;
  typedef logic signed [31:0] int32_t;
  typedef int32_t [1:0] int_2;
endpackage

// File: rtl/array_pair_serializer_pair_fifo.sv
// rtl/array_pair_serializer_pair_fifo.sv - DEPTH-entry FIFO of int_2 pairs with synchronous reset
module pair_fifo
  import scam_model_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  int_2                         push_data,
  input  logic                         pop,
  output int_2                         pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  int_2          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Requests against a full/empty FIFO are dropped so count can never leave [0, DEPTH].
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/array_pair_serializer.sv
// rtl/array_pair_serializer.sv - buffers int_2 pairs and re-emits them one element per handshake
module array_pair_serializer
  import scam_model_types::*;
  import array_pair_serializer_types::*;
#(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  int_2                         b_in,
  input  logic                         b_in_sync,
  output logic                         b_in_notify,
  output logic [31:0]                  b_out,
  input  logic                         b_out_sync,
  output logic                         b_out_notify,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  elems_sent
);
  localparam bit FIRST_IDX  = LSB_FIRST ? 1'b0 : 1'b1;
  localparam bit SECOND_IDX = ~FIRST_IDX;

  state_t state;
  state_t next_state;
  int_2   hold;
  int_2   fifo_head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   push;

  // Ready depends only on registered occupancy, never on b_in_sync.
  assign b_in_notify = !fifo_full;
  assign push        = b_in_sync && b_in_notify;

  pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (b_in),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  always_comb begin
    next_state   = state;
    pop          = 1'b0;
    b_out_notify = 1'b0;
    b_out        = B_OUT_IDLE;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SEND_A;
        end
      end
      SEND_A: begin
        b_out_notify = 1'b1;
        b_out        = hold[FIRST_IDX];
        if (b_out_sync) next_state = SEND_B;
      end
      SEND_B: begin
        b_out_notify = 1'b1;
        b_out        = hold[SECOND_IDX];
        // Refill the hold register on the last element's transfer so pairs stream without a bubble.
        if (b_out_sync) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            next_state = SEND_A;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      elems_sent <= ELEMS_SENT_RESET;
    end else begin
      state <= next_state;
      if (pop) hold <= fifo_head;
      if (b_out_notify && b_out_sync) elems_sent <= elems_sent + 32'd1;
    end
  end
endmodule

// File: tb/tb_array_pair_serializer.sv
// tb/tb_array_pair_serializer.sv - directed self-checking bench for array_pair_serializer
module tb_array_pair_serializer;
  import scam_model_types::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  int_2          b_in;
  logic          b_in_sync;
  logic          b_in_notify;
  logic [31:0]   b_out;
  logic          b_out_sync;
  logic          b_out_notify;
  logic [CW-1:0] occupancy;
  logic [31:0]   elems_sent;

  int errors = 0;
  int checks = 0;
  int_2 pairs [5];

  always #5 clk = ~clk;

  array_pair_serializer #(.DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .b_out        (b_out),
    .b_out_sync   (b_out_sync),
    .b_out_notify (b_out_notify),
    .occupancy    (occupancy),
    .elems_sent   (elems_sent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    b_in_sync  = 1'b0;
    b_out_sync = 1'b0;
    b_in       = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_pairs(input int n);
    b_in_sync = 1'b1;
    for (int i = 0; i < n; i++) begin
      b_in = pairs[i];
      step();
    end
    b_in_sync = 1'b0;
  endtask

  initial begin
    int   idx;
    logic held;
    logic [31:0] prev_val;

    pairs[0][0] = 32'sd11;          pairs[0][1] = 32'sd22;
    pairs[1][0] = -32'sd1;          pairs[1][1] = 32'h7fff_ffff;
    pairs[2][0] = 32'h8000_0000;    pairs[2][1] = 32'sd3;
    pairs[3][0] = 32'sd100;         pairs[3][1] = -32'sd100;
    pairs[4][0] = 32'sd42;          pairs[4][1] = 32'sd43;

    // Reset state
    do_reset();
    check("rst_in_notify", b_in_notify, 1);
    check("rst_out_notify", b_out_notify, 0);
    check("rst_b_out", b_out, 0);
    check("rst_occ", occupancy, 0);
    check("rst_elems", elems_sent, 0);

    // Single pair, first element one cycle after accept
    b_out_sync = 1'b1;
    b_in[0]    = 32'sd5;
    b_in[1]    = -32'sd7;
    b_in_sync  = 1'b1;
    step();
    b_in_sync = 1'b0;
    check("single_idle_notify", b_out_notify, 0);
    check("single_occ1", occupancy, 1);
    step();
    check("single_a_notify", b_out_notify, 1);
    check("single_a_data", b_out, 32'd5);
    check("single_a_occ", occupancy, 0);
    step();
    check("single_b_notify", b_out_notify, 1);
    check("single_b_data", b_out, 32'hffff_fff9);
    step();
    check("single_end_notify", b_out_notify, 0);
    check("single_end_b_out", b_out, 0);
    check("single_elems", elems_sent, 2);

    // Fill to full, then free one entry with a completed output pair
    do_reset();
    push_pairs(4);
    check("fill_occ3", occupancy, 3);
    check("fill_notify3", b_in_notify, 1);
    b_in_sync = 1'b1;
    b_in      = pairs[4];
    step();
    b_in_sync = 1'b0;
    check("fill_occ4", occupancy, 4);
    check("fill_full_notify", b_in_notify, 0);
    check("fill_head_a", b_out, pairs[0][0]);
    b_out_sync = 1'b1;
    step();
    check("fill_head_b", b_out, pairs[0][1]);
    check("fill_still_full", b_in_notify, 0);
    step();
    check("fill_refree_notify", b_in_notify, 1);
    check("fill_occ_after_pop", occupancy, 3);
    for (int i = 1; i < 5; i++) begin
      for (int e = 0; e < 2; e++) begin
        check("fill_drain_notify", b_out_notify, 1);
        check("fill_drain_data", b_out, pairs[i][e]);
        step();
      end
    end
    check("fill_end_notify", b_out_notify, 0);
    check("fill_end_occ", occupancy, 0);
    check("fill_elems", elems_sent, 10);

    // Back-to-back: three queued pairs stream on six consecutive cycles
    do_reset();
    push_pairs(3);
    check("b2b_occ", occupancy, 2);
    b_out_sync = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("b2b_notify", b_out_notify, 1);
      check("b2b_data", b_out, pairs[k / 2][k % 2]);
      step();
    end
    check("b2b_end_notify", b_out_notify, 0);
    check("b2b_elems", elems_sent, 6);

    // Random backpressure: order preserved, data stable while stalled
    do_reset();
    push_pairs(3);
    idx  = 0;
    held = 1'b0;
    prev_val = '0;
    for (int cyc = 0; cyc < 200 && idx < 6; cyc++) begin
      b_out_sync = 1'($urandom_range(0, 1));
      if (b_out_notify) begin
        check("bp_data", b_out, pairs[idx / 2][idx % 2]);
        if (held) check("bp_stable", b_out, prev_val);
      end
      held     = b_out_notify && !b_out_sync;
      prev_val = b_out;
      if (b_out_notify && b_out_sync) idx++;
      step();
    end
    b_out_sync = 1'b0;
    check("bp_done", idx, 6);
    check("bp_elems", elems_sent, 6);

    // Reset in SEND_B with two pairs queued
    do_reset();
    push_pairs(3);
    b_out_sync = 1'b1;
    step();
    b_out_sync = 1'b0;
    check("mid_pre_occ", occupancy, 2);
    check("mid_pre_data", b_out, pairs[0][1]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_occ", occupancy, 0);
    check("mid_out_notify", b_out_notify, 0);
    check("mid_b_out", b_out, 0);
    check("mid_in_notify", b_in_notify, 1);
    check("mid_elems", elems_sent, 0);
    b_out_sync = 1'b1;
    step();
    step();
    check("mid_no_survivor", b_out_notify, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
